fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the CPU core's decode/execute path. It owns the program counter and issues word-addressed requests to instruction memory over a req/ack handshake. Returned instructions are buffered in a small prefetch FIFO and presented to decode through a valid/ready interface. A redirect input from execute (branch/jump) flushes the queue and restarts fetch at a new address.

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit_fifo.sv | 46 ++++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default geometry,
// reset PC and the request-tracking state encoding.
package fetch_unit_pkg;

  localparam int FU_ADDR_W   = 8;
  localparam int FU_INSTR_W  = 16;
  localparam int FU_DEPTH    = 4;
  localparam int FU_RESET_PC = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: instruction memory req/ack, redirect from
// execute, and the valid/ready instruction stream toward decode.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = FU_ADDR_W,
  parameter int INSTR_W = FU_INSTR_W
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_data, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_data, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO holding {instruction, address} pairs; flush empties it in
// one cycle. Storage is cleared by reset so the head reads zero after reset.
module fetch_unit_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 24,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             pcrst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, wr_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge pcrst) begin
    if (!pcrst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop) rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign count = cnt_q;
  assign head  = mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding memory
// request at a time, buffers returns in a prefetch FIFO, and handles redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = FU_ADDR_W,
  parameter int                INSTR_W  = FU_INSTR_W,
  parameter int                DEPTH    = FU_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FU_RESET_PC)
) (
  input logic        clk,
  input logic        pcrst,
  fetch_unit_if.master bus
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = INSTR_W + ADDR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, pc_inc;
  logic              push, pop, flush, space;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ENTRY_W-1:0] head;

  // A redirect flushes the queue, so it overrides both the push and the pop.
  assign flush   = bus.redirect_valid;
  assign pop     = bus.instr_valid & bus.instr_ready & ~flush;
  assign push    = (state_q == BUSY) & bus.imem_ack & ~flush;
  assign cnt_nxt = cnt + CNT_W'(push) - CNT_W'(pop);
  assign space   = cnt_nxt < CNT_W'(DEPTH);
  assign pc_inc  = pc_q + ADDR_W'(1);

  fetch_unit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .pcrst (pcrst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({bus.imem_data, bus.imem_addr}),
    .count (cnt),
    .head  (head)
  );

  always_ff @(posedge clk or negedge pcrst) begin
    if (!pcrst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
      unique case (state_q)
        IDLE: begin
          state_d = BUSY;
          addr_d  = bus.redirect_pc;
        end
        BUSY, DROP: begin
          // The old request must still complete; its address stays on the bus.
          if (bus.imem_ack) begin
            state_d = BUSY;
            addr_d  = bus.redirect_pc;
          end else begin
            state_d = DROP;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (space) begin
            state_d = BUSY;
            addr_d  = pc_q;
          end
        end
        BUSY: begin
          if (bus.imem_ack) begin
            pc_d = pc_inc;
            if (space) addr_d  = pc_inc;
            else       state_d = IDLE;
          end
        end
        DROP: begin
          if (bus.imem_ack) begin
            state_d = BUSY;
            addr_d  = pc_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.imem_req    = (state_q != IDLE);
    bus.imem_addr   = addr_q;
    bus.instr_valid = (cnt != '0);
    bus.instr       = head[ENTRY_W-1:ADDR_W];
    bus.instr_pc    = head[ADDR_W-1:0];
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirect with a
// dropped request, redirect racing an ack and pop, PC wrap, async reset.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic pcrst;
  logic ack_en;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) bm ();
  fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) bw ();

  // Memory returns 0x1000 + address; main DUT's ack can be withheld.
  assign bm.imem_ack  = bm.imem_req & ack_en;
  assign bm.imem_data = 16'h1000 + {8'h00, bm.imem_addr};

  assign bw.imem_ack       = bw.imem_req;
  assign bw.imem_data      = 16'h1000 + {8'h00, bw.imem_addr};
  assign bw.redirect_valid = 1'b0;
  assign bw.redirect_pc    = 8'h00;
  assign bw.instr_ready    = 1'b1;

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .DEPTH(4), .RESET_PC(8'h00)) u_dut (
    .clk   (clk),
    .pcrst (pcrst),
    .bus   (bm.master)
  );

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .DEPTH(4), .RESET_PC(8'hFE)) u_wrap (
    .clk   (clk),
    .pcrst (pcrst),
    .bus   (bw.master)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart();
    pcrst = 1'b0;
    tick(2);
    pcrst = 1'b1;
  endtask

  initial begin
    pcrst             = 1'b1;
    ack_en            = 1'b1;
    bm.instr_ready    = 1'b1;
    bm.redirect_valid = 1'b0;
    bm.redirect_pc    = 8'h00;
    #2 pcrst = 1'b0;
    #1;
    chk("rst_req",   bm.imem_req,    0);
    chk("rst_addr",  bm.imem_addr,   0);
    chk("rst_valid", bm.instr_valid, 0);
    chk("rst_instr", bm.instr,       0);
    chk("rst_ipc",   bm.instr_pc,    0);
    chk("rst_waddr", bw.imem_addr,   32'hFE);
    tick(2);
    pcrst = 1'b1;

    // streaming with zero-wait memory
    tick(1);
    chk("s1_req",   bm.imem_req,    1);
    chk("s1_addr",  bm.imem_addr,   0);
    chk("s1_valid", bm.instr_valid, 0);
    chk("w1_addr",  bw.imem_addr,   32'hFE);
    tick(1);
    chk("s2_valid", bm.instr_valid, 1);
    chk("s2_instr", bm.instr,       32'h1000);
    chk("s2_ipc",   bm.instr_pc,    0);
    chk("w2_ipc",   bw.instr_pc,    32'hFE);
    chk("w2_instr", bw.instr,       32'h10FE);
    tick(1);
    chk("s3_instr", bm.instr,       32'h1001);
    chk("s3_ipc",   bm.instr_pc,    1);
    chk("w3_ipc",   bw.instr_pc,    32'hFF);
    tick(1);
    chk("s4_instr", bm.instr,       32'h1002);
    chk("s4_ipc",   bm.instr_pc,    2);
    chk("w4_ipc",   bw.instr_pc,    32'h00);
    chk("w4_instr", bw.instr,       32'h1000);

    // back-pressure fills the FIFO and stops fetch
    bm.instr_ready = 1'b0;
    restart();
    tick(4);
    chk("bp4_req",  bm.imem_req,  1);
    chk("bp4_addr", bm.imem_addr, 3);
    tick(1);
    chk("bp5_req",  bm.imem_req,  0);
    tick(5);
    chk("bp10_req",   bm.imem_req,    0);
    chk("bp10_valid", bm.instr_valid, 1);
    chk("bp10_instr", bm.instr,       32'h1000);
    chk("bp10_ipc",   bm.instr_pc,    0);
    bm.instr_ready = 1'b1;
    tick(1);
    chk("rel1_instr", bm.instr,     32'h1001);
    chk("rel1_req",   bm.imem_req,  1);
    chk("rel1_addr",  bm.imem_addr, 4);
    tick(1);
    chk("rel2_instr", bm.instr, 32'h1002);
    tick(1);
    chk("rel3_instr", bm.instr, 32'h1003);
    tick(1);
    chk("rel4_instr", bm.instr,    32'h1004);
    chk("rel4_ipc",   bm.instr_pc, 4);

    // redirect during a slow request: old data dropped
    ack_en = 1'b0;
    restart();
    tick(2);
    bm.redirect_valid = 1'b1;
    bm.redirect_pc    = 8'h40;
    tick(1);
    bm.redirect_valid = 1'b0;
    chk("drop_req",   bm.imem_req,    1);
    chk("drop_addr",  bm.imem_addr,   0);
    chk("drop_valid", bm.instr_valid, 0);
    tick(1);
    ack_en = 1'b1;
    tick(1);
    chk("dack_addr",  bm.imem_addr,   32'h40);
    chk("dack_req",   bm.imem_req,    1);
    chk("dack_valid", bm.instr_valid, 0);
    tick(1);
    chk("new_valid", bm.instr_valid, 1);
    chk("new_ipc",   bm.instr_pc,    32'h40);
    chk("new_instr", bm.instr,       32'h1040);

    // redirect on the same edge as an ack and a pop
    bm.redirect_valid = 1'b1;
    bm.redirect_pc    = 8'h80;
    tick(1);
    bm.redirect_valid = 1'b0;
    chk("race_valid", bm.instr_valid, 0);
    chk("race_req",   bm.imem_req,    1);
    chk("race_addr",  bm.imem_addr,   32'h80);
    tick(1);
    chk("race_ipc",   bm.instr_pc, 32'h80);
    chk("race_instr", bm.instr,    32'h1080);

    // async reset while a request waits
    ack_en = 1'b0;
    tick(1);
    chk("pre_req",  bm.imem_req,  1);
    chk("pre_addr", bm.imem_addr, 32'h81);
    #3 pcrst = 1'b0;
    #1;
    chk("ar_req",   bm.imem_req,    0);
    chk("ar_addr",  bm.imem_addr,   0);
    chk("ar_valid", bm.instr_valid, 0);
    chk("ar_instr", bm.instr,       0);
    chk("ar_ipc",   bm.instr_pc,    0);
    @(posedge clk);
    #1;
    pcrst  = 1'b1;
    ack_en = 1'b1;
    tick(1);
    chk("rs_req",  bm.imem_req,  1);
    chk("rs_addr", bm.imem_addr, 0);
    tick(1);
    chk("rs_ipc",   bm.instr_pc, 0);
    chk("rs_instr", bm.instr,    32'h1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
